// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter.
// Optional feature macro: SERIAL_WORD_TX_PARITY_EN adds the even-parity state.
package serial_pkg;

  localparam int WIDTH_DEFAULT = 16;

`ifdef SERIAL_WORD_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/serial_word_tx_piso_reg.sv
// Loadable MSB-first parallel-in / serial-out register.
// Load has priority over shift; zeros are shifted in at the LSB.
module piso_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next contents: capture a new word, or move every bit one place toward the MSB.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end else if (shift) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  // Register update; reset clears the word so a dropped handshake leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_msb = data_q[WIDTH-1];

endmodule

// File: rtl/serial_word_tx.sv
// Serial word transmitter: accepts a WIDTH-bit word on a valid/ready handshake
// and emits it MSB first on sd, one bit per cycle, then pulses done.
// Optional feature macro: SERIAL_WORD_TX_PARITY_EN appends one even-parity bit.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sd,
  output logic             sd_valid,
  output logic             busy,
  output logic             done
);

  // One spare bit so an out-of-range counter value is representable and detectable.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;
  logic             hs;
  logic             last_bit;
  logic             cnt_bad;
  logic             piso_msb;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             par_q;
  logic             par_d;
`endif

  assign hs       = in_valid && (state_q == ST_IDLE);
  assign cnt_bad  = (cnt_q > CNT_MAX);
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == '0);

  piso_reg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .shift (state_q == ST_SHIFT),
    .d     (in_data),
    .q_msb (piso_msb)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a corrupted counter drops straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_bad) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      ST_PAR: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: frame bits only while SHIFT (or PAR), everything quiet otherwise.
  always_comb begin
    in_ready = 1'b0;
    sd       = 1'b0;
    sd_valid = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SHIFT: begin
        sd       = piso_msb;
        sd_valid = 1'b1;
        busy     = 1'b1;
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      ST_PAR: begin
        sd       = par_q;
        sd_valid = 1'b1;
        busy     = 1'b1;
      end
`endif
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end
  assign done = done_q;

  // Counter, done pulse and running parity for the next cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (hs) begin
      cnt_d = CNT_MAX;
    end else if ((state_q == ST_SHIFT) && !cnt_bad && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
`ifdef SERIAL_WORD_TX_PARITY_EN
    done_d = (state_q == ST_PAR);
    par_d  = par_q;
    if (hs) begin
      par_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      par_d = par_q ^ piso_msb;
    end
`else
    done_d = last_bit;
`endif
  end

  // Counter and done registers; reset aborts a frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench for serial_word_tx (WIDTH = 16).
module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        sd;
  logic        sd_valid;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  logic [3:0] shreg;

  serial_word_tx #(
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sd       (sd),
    .sd_valid (sd_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_sd"}, 32'(sd), 32'd0);
    check_eq({tag, "_sdv"}, 32'(sd_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called just after the handshake edge. Walks the frame bits (exp_bits MSB
  // first) and ends in the done cycle without advancing past it.
  task automatic frame_check(input string tag, input logic [15:0] exp_bits,
                             input logic exp_par, input bit poke);
    shreg = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s_sd%0d", tag, i), 32'(sd), 32'(exp_bits[15-i]));
      check_eq($sformatf("%s_v%0d", tag, i), 32'({sd_valid, busy, in_ready, done}), 32'b1100);
      shreg = {shreg[2:0], sd};
      if (poke && i == 5) begin
        in_valid = 1'b1;
        in_data  = 16'h0000;
      end
      step();
      if (poke && i == 5) in_valid = 1'b0;
    end
    if (PAR_EN) begin
      check_eq({tag, "_par"}, 32'(sd), 32'(exp_par));
      check_eq({tag, "_parv"}, 32'({sd_valid, busy, done}), 32'b110);
      step();
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_idle({tag, "_gap"});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    step();
    step();
    rst = 1'b0;
    check_idle("rst");
    check_eq("rst_done", 32'(done), 32'd0);
    step();
    check_idle("idle");

    // Single word 16'h51FB, in_data scrambled right after the handshake.
    in_valid = 1'b1;
    in_data  = 16'h51FB;
    step();
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    frame_check("w51fb", 16'b0101_0001_1111_1011, 1'b0, 1'b0);
    check_eq("w51fb_shreg", 32'(shreg), 32'b1011);
    step();
    check_eq("w51fb_done_off", 32'(done), 32'd0);
    check_idle("w51fb_after");

    // Parity of a single set bit, with an in_valid poke mid-frame.
    in_valid = 1'b1;
    in_data  = 16'h0001;
    step();
    in_valid = 1'b0;
    frame_check("w0001", 16'h0001, 1'b1, 1'b1);
    step();
    check_eq("w0001_done_off", 32'(done), 32'd0);

    // Back-to-back: in_valid held high, second word taken in the done cycle.
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    step();
    in_data  = 16'h5555;
    frame_check("waaaa", 16'hAAAA, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    in_data  = 16'h0000;
    frame_check("w5555", 16'h5555, 1'b0, 1'b0);
    step();
    check_idle("b2b_end");

    // Abort with reset while bit 5 of 16'hFFFF is on the line.
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("abort_bit5", 32'({sd, sd_valid}), 32'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort");
    check_eq("abort_done", 32'(done), 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
        if (done || sd_valid) seen_done++;
        step();
      end
      check_eq("abort_quiet", 32'(seen_done), 32'd0);
    end

    // Reset dominates a simultaneous handshake: the word is dropped.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle("rst_hs");
    step();
    check_idle("rst_hs_drop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter WIDTH, default 16: number of data bits per word; SHALL be at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream word offered.
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 in_data  input  WIDTH  word to serialize, sampled only at handshake.
REQ-007 sd  output  1  serial bit, feeds the d input of the downstream serial-in shift register.
REQ-008 sd_valid  output  1  sd carries a frame bit this cycle.
REQ-009 busy  output  1  a frame is in progress.
REQ-010 done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-011 States SHALL be IDLE, SHIFT and, with parity compiled in, PAR.
REQ-012 in_ready SHALL equal (state == IDLE); a handshake SHALL be in_valid && in_ready at a rising edge.
REQ-013 On handshake, the word SHALL be loaded into an internal WIDTH-bit register, the bit counter SHALL be set to WIDTH-1, and the state SHALL become SHIFT.
REQ-014 In SHIFT, sd SHALL present the bits MSB first, one per cycle, with sd_valid=1 and busy=1; bit in_data[WIDTH-1] SHALL appear in the first cycle after the handshake.
REQ-015 SHIFT SHALL last exactly WIDTH cycles; on the last bit (counter==0) the next state SHALL be PAR if compiled in, otherwise IDLE.
REQ-016 Frame latency: first bit 1 cycle after handshake; done SHALL pulse in the first IDLE cycle after the frame (cycle WIDTH+1 after handshake without parity, WIDTH+2 with parity).
REQ-017 Back-to-back words: in_ready is 1 in the same cycle as done, so the minimum word-to-word spacing SHALL be WIDTH+1 cycles without parity (WIDTH+2 with parity), leaving a one-cycle sd_valid=0 gap.
REQ-018 in_valid while not IDLE SHALL be ignored; in_data changes after handshake SHALL NOT affect the frame.
REQ-019 Outside frames, sd SHALL be 0 and sd_valid, busy and done SHALL be 0, except done as in REQ-016.
REQ-020 The counter SHALL never wrap; a counter value outside 0..WIDTH-1 in SHIFT SHALL force IDLE.

Reset
REQ-021 When rst=1 at an edge: state SHALL become IDLE, and sd, sd_valid, busy, done, the counter and the data register SHALL become 0; in_ready SHALL then be 1.
REQ-022 Reset mid-frame SHALL abort the frame with no done pulse; rst SHALL dominate a simultaneous handshake, and that word SHALL be dropped.

Configuration
REQ-023 Macro SERIAL_WORD_TX_PARITY_EN: when defined, PAR SHALL emit one extra bit sd = XOR of the loaded word (even parity) with sd_valid=1; when undefined, PAR SHALL NOT exist and frames SHALL be exactly WIDTH bits.

Structure
REQ-024 Package serial_pkg SHALL hold the state enumeration and the default WIDTH constant (16).
REQ-025 The loadable MSB-first parallel-in serial-out register SHALL be one sub-module, piso_reg (load, shift, q_msb); the FSM and counter SHALL stay in serial_word_tx.

Verification
REQ-026 Reset, then idle: rst=1 for 2 cycles, then 0 -> in_ready=1; sd, sd_valid, busy and done all 0.
REQ-027 Single word: in_data=16'h51FB with one handshake -> sd over the next 16 cycles = 0,1,0,1,0,0,0,1,1,1,1,1,1,0,1,1; the downstream 4-bit shift register then holds 4'b1011; done pulses at cycle 17 without parity.
REQ-028 Parity: with SERIAL_WORD_TX_PARITY_EN defined, 16'h0001 -> 17th bit sd=1; 16'h51FB -> 17th bit sd=0; done pulses at cycle 18.
REQ-029 Back-to-back: in_valid held 1 with 16'hAAAA then 16'h5555 -> second handshake in the done cycle; exactly one sd_valid=0 gap cycle between frames.
REQ-030 Abort and ignore: rst=1 at bit 5 of 16'hFFFF -> next cycle IDLE, sd_valid=0, no done; in_valid pulsed during a frame -> no effect on the sd sequence.
